// File: rtl/csla_stream_accumulator.sv
// csla_stream_accumulator: accumulates a run of 32-bit operands using the
// BEC carry-select adder. Operands arrive on a valid/ready stream. The total,
// a sticky unsigned-overflow flag and the operand count leave on a
// valid/ready result port.

// bitmodifiedcarrylook: 32-bit carry-select adder without carry-in.
// Each 4-bit group forms its sum assuming carry-in 0 with a ripple adder. A
// binary-to-excess-1 converter (BEC) derives the carry-in 1 result from that
// sum. The real group carry then selects one of the two.
module bitmodifiedcarrylook (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum,
  output logic        cout
);
  localparam int GW = 4;
  localparam int NG = 32 / GW;

  logic [GW:0] grp_rca;
  logic [GW:0] grp_bec;
  logic        rc;
  logic        ones;
  logic        carry;

  // Group-wise ripple sum, BEC increment, and carry-driven select.
  always_comb begin
    // NOTE: every variable gets a value before any branch reads or writes it,
    // so no path can leave one unassigned and infer a latch.
    sum     = '0;
    carry   = 1'b0;
    grp_rca = '0;
    grp_bec = '0;
    rc      = 1'b0;
    ones    = 1'b0;
    for (int g = 0; g < NG; g++) begin
      rc = 1'b0;
      for (int i = 0; i < GW; i++) begin
        grp_rca[i] = a[g*GW+i] ^ b[g*GW+i] ^ rc;
        rc = (a[g*GW+i] & b[g*GW+i]) | (rc & (a[g*GW+i] ^ b[g*GW+i]));
      end
      grp_rca[GW] = rc;
      // BEC: add one to {carry, sum} by flipping each bit below which all
      // lower bits are ones.
      ones = 1'b1;
      for (int i = 0; i <= GW; i++) begin
        grp_bec[i] = grp_rca[i] ^ ones;
        ones = ones & grp_rca[i];
      end
      if (carry) begin
        sum[g*GW +: GW] = grp_bec[GW-1:0];
        carry           = grp_bec[GW];
      end else begin
        sum[g*GW +: GW] = grp_rca[GW-1:0];
        carry           = grp_rca[GW];
      end
    end
    cout = carry;
  end
endmodule

module csla_stream_accumulator #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_ops,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_cnt,
  input  logic             out_ready,
  output logic             busy
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;

  logic [31:0]      add_sum;
  logic             add_cout;

  // The adder has no carry-in, so the sum is simply acc + operand.
  bitmodifiedcarrylook u_adder (
    .a    (acc_q),
    .b    (in_data),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // The handshake outputs depend only on the state. The result fields come
  // straight from the registers, so they hold in IDLE until the next start.
  assign in_ready  = (state_q == S_ACCUM);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_cnt   = cnt_q;

  // Next-state and datapath update. Every register holds unless a branch
  // changes it.
  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    cnt_d       = cnt_q;
    remaining_d = remaining_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d = '0;
          ovf_d = 1'b0;
          cnt_d = '0;
          if (num_ops != '0) begin
            remaining_d = num_ops;
            state_d     = S_ACCUM;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          acc_d       = add_sum;
          ovf_d       = ovf_q | add_cout;
          cnt_d       = cnt_q + CNT_W'(1);
          remaining_d = remaining_q - CNT_W'(1);
          if (remaining_q == CNT_W'(1)) begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers. Reset aborts any run in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      cnt_q       <= '0;
      remaining_q <= '0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the values
      // from before the edge, whatever order these statements are in.
      state_q     <= state_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      cnt_q       <= cnt_d;
      remaining_q <= remaining_d;
    end
  end
endmodule

// File: tb/tb_csla_stream_accumulator.sv
// Directed bench for csla_stream_accumulator. Inputs change and outputs are
// sampled on the falling edge. A bench-side model computes each run's
// expected result. That result is queued when the run's last operand is
// driven and compared when the DUT presents its output.
module tb_csla_stream_accumulator;
  localparam int CNT_W = 8;

  typedef struct {
    logic [31:0]      sum;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] num_ops;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic             out_valid;
  logic [31:0]      out_sum;
  logic             out_ovf;
  logic [CNT_W-1:0] out_cnt;
  logic             out_ready;
  logic             busy;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];

  logic [31:0]      model_sum;
  logic             model_ovf;
  logic [CNT_W-1:0] model_cnt;

  csla_stream_accumulator #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_ops   (num_ops),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf),
    .out_cnt   (out_cnt),
    .out_ready (out_ready),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue a one-cycle start pulse and reset the reference model.
  task automatic begin_run(input logic [CNT_W-1:0] n);
    start     = 1'b1;
    num_ops   = n;
    model_sum = '0;
    model_ovf = 1'b0;
    model_cnt = '0;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one operand for one cycle. in_ready must be high so the next
  // edge accepts it.
  task automatic send_op(input string tag, input logic [31:0] d);
    logic [32:0] wide;
    check(tag, in_ready, 1'b1);
    in_valid  = 1'b1;
    in_data   = d;
    wide      = {1'b0, model_sum} + {1'b0, d};
    model_sum = wide[31:0];
    model_ovf = model_ovf | wide[32];
    model_cnt = model_cnt + 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic push_expected();
    exp_t e;
    e.sum = model_sum;
    e.ovf = model_ovf;
    e.cnt = model_cnt;
    sb.push_back(e);
  endtask

  // Wait (bounded) for out_valid, compare against the scoreboard, let the
  // handshake complete, then confirm the block has returned to IDLE.
  task automatic expect_result(input string tag);
    exp_t e;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) @(negedge clk);
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_sb_nonempty"}, sb.size() > 0, 1'b1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_sum"}, out_sum, e.sum);
      check({tag, "_ovf"}, out_ovf, e.ovf);
      check({tag, "_cnt"}, out_cnt, e.cnt);
    end
    @(negedge clk);
    check({tag, "_valid_drop"}, out_valid, 1'b0);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    num_ops   = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_sum", out_sum, 32'h0);
    check("rst_out_ovf", out_ovf, 1'b0);
    check("rst_out_cnt", out_cnt, '0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Run 1: 1+2+3, out_ready already high
    out_ready = 1'b1;
    begin_run(8'd3);
    check("t1_busy", busy, 1'b1);
    send_op("t1_rdy0", 32'd1);
    send_op("t1_rdy1", 32'd2);
    send_op("t1_rdy2", 32'd3);
    push_expected();
    check("t1_valid_next_cycle", out_valid, 1'b1);
    check("t1_in_ready_low", in_ready, 1'b0);
    expect_result("t1");
    check("t1_sum_held_idle", out_sum, 32'd6);

    // Run 2: wrap with overflow
    begin_run(8'd2);
    send_op("t2_rdy0", 32'hFFFF_FFFF);
    send_op("t2_rdy1", 32'h0000_0002);
    push_expected();
    check("t2_model_sum", model_sum, 32'h0000_0001);
    expect_result("t2");

    // Run 3: bubbles on in_valid (1,0,0,1,1,0,1)
    begin_run(8'd4);
    send_op("t3_rdy0", 32'h10);
    repeat (2) @(negedge clk);
    send_op("t3_rdy1", 32'h20);
    send_op("t3_rdy2", 32'h30);
    @(negedge clk);
    send_op("t3_rdy3", 32'h40);
    push_expected();
    check("t3_in_ready_after_last", in_ready, 1'b0);
    check("t3_cnt_now", out_cnt, 8'd4);
    expect_result("t3");

    // Run 4: output backpressure with start and in_valid pulsed in DONE
    out_ready = 1'b0;
    begin_run(8'd2);
    send_op("t4_rdy0", 32'h8000_0000);
    send_op("t4_rdy1", 32'h8000_0001);
    push_expected();
    for (int i = 0; i < 5; i++) begin
      start    = (i == 1 || i == 2);
      num_ops  = 8'd7;
      in_valid = (i == 2 || i == 3);
      in_data  = 32'h1234_5678;
      check("t4_hold_valid", out_valid, 1'b1);
      check("t4_hold_sum", out_sum, model_sum);
      check("t4_hold_ovf", out_ovf, model_ovf);
      check("t4_hold_cnt", out_cnt, model_cnt);
      @(negedge clk);
    end
    start    = 1'b0;
    in_valid = 1'b0;
    expect_result("t4");
    check("t4_cnt_kept", out_cnt, 8'd2);
    @(negedge clk);
    check("t4_no_new_run", busy, 1'b0);

    // Run 5: empty run
    begin_run(8'd0);
    push_expected();
    check("t5_valid_next_cycle", out_valid, 1'b1);
    expect_result("t5");

    // Run 6: asynchronous reset after two of five operands
    out_ready = 1'b0;
    begin_run(8'd5);
    send_op("t6_rdy0", 32'h3);
    send_op("t6_rdy1", 32'h4);
    check("t6_partial_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_in_ready", in_ready, 1'b0);
    check("t6_rst_out_valid", out_valid, 1'b0);
    check("t6_rst_out_sum", out_sum, 32'h0);
    check("t6_rst_out_ovf", out_ovf, 1'b0);
    check("t6_rst_out_cnt", out_cnt, '0);
    check("t6_rst_busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_idle_after_release", busy, 1'b0);

    // Run 7: single operand after the aborted run
    begin_run(8'd1);
    send_op("t7_rdy0", 32'h7);
    push_expected();
    expect_result("t7");

    check("sb_empty_at_end", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
